// File: rtl/wb_addr_window_adapter.sv
// Wishbone classic address-window adapter: rebases one aligned window of a wide
// upstream bus onto a narrower downstream bus through a single register stage.
module wb_addr_window_adapter #(
  parameter int unsigned                IN_ADDR_WIDTH  = 32,
  parameter int unsigned                OUT_ADDR_WIDTH = 16,
  parameter int unsigned                DATA_WIDTH     = 32,
  parameter logic [IN_ADDR_WIDTH-1:0]   WIN_BASE       = '0,
  parameter int unsigned                WIN_SIZE_LOG2  = 16,
  parameter int unsigned                TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        i_cyc,
  input  logic                        i_stb,
  input  logic                        i_we,
  input  logic [IN_ADDR_WIDTH-1:0]    i_adr,
  input  logic [DATA_WIDTH-1:0]       i_dat_w,
  input  logic [DATA_WIDTH/8-1:0]     i_sel,
  input  logic [2:0]                  i_cti,
  input  logic [1:0]                  i_bte,
  output logic [DATA_WIDTH-1:0]       i_dat_r,
  output logic                        i_ack,
  output logic                        i_err,
  output logic                        o_cyc,
  output logic                        o_stb,
  output logic                        o_we,
  output logic [OUT_ADDR_WIDTH-1:0]   o_adr,
  output logic [DATA_WIDTH-1:0]       o_dat_w,
  output logic [DATA_WIDTH/8-1:0]     o_sel,
  output logic [2:0]                  o_cti,
  output logic [1:0]                  o_bte,
  input  logic [DATA_WIDTH-1:0]       o_dat_r,
  input  logic                        o_ack,
  input  logic                        o_err,
  output logic                        timeout_o
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_RESP,
    S_LERR
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [OUT_ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]       dat_w_q, dat_w_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic                        we_q, we_d;
  logic [DATA_WIDTH-1:0]       dat_r_q, dat_r_d;
  logic                        err_q, err_d;
  logic                        tmo_q, tmo_d;

  logic                        hit;
  logic [OUT_ADDR_WIDTH-1:0]   rebased;

  // Bursts are degraded to classic cycles, so the burst hints are never consumed.
  logic unused_burst;
  assign unused_burst = ^{i_cti, i_bte};

  if (WIN_SIZE_LOG2 >= IN_ADDR_WIDTH) begin : g_all_hit
    assign hit = 1'b1;
  end else begin : g_cmp
    assign hit = (i_adr[IN_ADDR_WIDTH-1:WIN_SIZE_LOG2] ==
                  WIN_BASE[IN_ADDR_WIDTH-1:WIN_SIZE_LOG2]);
  end

  assign rebased = OUT_ADDR_WIDTH'(i_adr[WIN_SIZE_LOG2-1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_w_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      dat_r_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_r_q <= dat_r_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_w_d = dat_w_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_r_d = dat_r_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        tmo_d = 1'b0;
        cnt_d = '0;
        if (i_cyc && i_stb) begin
          if (hit) begin
            state_d = S_FWD;
            adr_d   = rebased;
            dat_w_d = i_dat_w;
            sel_d   = i_sel;
            we_d    = i_we;
          end else begin
            state_d = S_LERR;
          end
        end
      end
      S_FWD: begin
        // Abort beats any termination; ERR beats ACK; a real termination beats the timeout.
        if (!i_cyc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (o_err) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (o_ack) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          dat_r_d = o_dat_r;
          cnt_d   = '0;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_LERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_cyc     = (state_q == S_FWD);
    o_stb     = (state_q == S_FWD);
    i_ack     = (state_q == S_RESP) && !err_q;
    i_err     = (state_q == S_LERR) || ((state_q == S_RESP) && err_q);
    timeout_o = (state_q == S_RESP) && tmo_q;
  end

  assign o_adr   = adr_q;
  assign o_dat_w = dat_w_q;
  assign o_sel   = sel_q;
  assign o_we    = we_q;
  assign o_cti   = 3'b000;
  assign o_bte   = 2'b00;
  assign i_dat_r = dat_r_q;

endmodule

// File: tb/tb_wb_addr_window_adapter.sv
// Directed bench for wb_addr_window_adapter: window 0x4000_0000/64K, 16-bit
// downstream address, 4-cycle downstream timeout.
module tb_wb_addr_window_adapter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_cyc, i_stb, i_we;
  logic [31:0] i_adr;
  logic [31:0] i_dat_w;
  logic [3:0]  i_sel;
  logic [2:0]  i_cti;
  logic [1:0]  i_bte;
  logic [31:0] i_dat_r;
  logic        i_ack, i_err;
  logic        o_cyc, o_stb, o_we;
  logic [15:0] o_adr;
  logic [31:0] o_dat_w;
  logic [3:0]  o_sel;
  logic [2:0]  o_cti;
  logic [1:0]  o_bte;
  logic [31:0] o_dat_r;
  logic        o_ack, o_err;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  wb_addr_window_adapter #(
    .IN_ADDR_WIDTH (32),
    .OUT_ADDR_WIDTH(16),
    .DATA_WIDTH    (32),
    .WIN_BASE      (32'h4000_0000),
    .WIN_SIZE_LOG2 (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_cyc    (i_cyc),
    .i_stb    (i_stb),
    .i_we     (i_we),
    .i_adr    (i_adr),
    .i_dat_w  (i_dat_w),
    .i_sel    (i_sel),
    .i_cti    (i_cti),
    .i_bte    (i_bte),
    .i_dat_r  (i_dat_r),
    .i_ack    (i_ack),
    .i_err    (i_err),
    .o_cyc    (o_cyc),
    .o_stb    (o_stb),
    .o_we     (o_we),
    .o_adr    (o_adr),
    .o_dat_w  (o_dat_w),
    .o_sel    (o_sel),
    .o_cti    (o_cti),
    .o_bte    (o_bte),
    .o_dat_r  (o_dat_r),
    .o_ack    (o_ack),
    .o_err    (o_err),
    .timeout_o(timeout_o)
  );

  task automatic test_reset();
    rst_i = 1'b1;
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_w = '0; i_sel = '0;
    i_cti = '0; i_bte = '0; o_dat_r = '0; o_ack = 0; o_err = 0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({o_cyc, o_stb, o_we, i_ack, i_err, timeout_o} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 000000", {o_cyc, o_stb, o_we, i_ack, i_err, timeout_o});
    end
    total++;
    if ({i_dat_r, o_adr, o_dat_w, o_sel, o_cti, o_bte} !== 89'b0) begin
      bad++; $display("FAIL reset_data: dat_r=%h adr=%h dat_w=%h sel=%h want all 0", i_dat_r, o_adr, o_dat_w, o_sel);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_read();
    i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 32'h4000_1234; i_sel = 4'hF;
    @(negedge clk_i);
    total++;
    if ({o_cyc, o_stb, o_we} !== 3'b110) begin
      bad++; $display("FAIL read_ostb: got %b want 110", {o_cyc, o_stb, o_we});
    end
    total++;
    if (o_adr !== 16'h1234) begin
      bad++; $display("FAIL read_oadr: got %h want 1234", o_adr);
    end
    total++;
    if ({o_sel, o_cti, o_bte} !== {4'hF, 3'b000, 2'b00}) begin
      bad++; $display("FAIL read_sel: got sel=%h cti=%b bte=%b want f 000 00", o_sel, o_cti, o_bte);
    end
    total++;
    if ({i_ack, i_err} !== 2'b00) begin
      bad++; $display("FAIL read_early: got ack/err=%b want 00", {i_ack, i_err});
    end
    o_ack = 1; o_dat_r = 32'hDEAD_BEEF;
    @(negedge clk_i);
    o_ack = 0; o_dat_r = '0;
    total++;
    if ({i_ack, i_err, o_cyc, o_stb} !== 4'b1000) begin
      bad++; $display("FAIL read_resp: got ack,err,cyc,stb=%b want 1000", {i_ack, i_err, o_cyc, o_stb});
    end
    total++;
    if (i_dat_r !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL read_data: got %h want deadbeef", i_dat_r);
    end
    i_cyc = 0; i_stb = 0;
    @(negedge clk_i);
    total++;
    if ({i_ack, i_err} !== 2'b00 || i_dat_r !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL read_after: got ack/err=%b dat=%h want 00 deadbeef", {i_ack, i_err}, i_dat_r);
    end
  endtask

  task automatic test_miss();
    i_cyc = 1; i_stb = 1; i_we = 1; i_adr = 32'h5000_0000; i_dat_w = 32'h1111_2222;
    @(negedge clk_i);
    total++;
    if ({i_err, i_ack, o_cyc, o_stb} !== 4'b1000) begin
      bad++; $display("FAIL miss_err: got err,ack,cyc,stb=%b want 1000", {i_err, i_ack, o_cyc, o_stb});
    end
    i_cyc = 0; i_stb = 0; i_we = 0;
    @(negedge clk_i);
    total++;
    if ({i_err, i_ack, o_cyc} !== 3'b000) begin
      bad++; $display("FAIL miss_after: got err,ack,cyc=%b want 000", {i_err, i_ack, o_cyc});
    end
  endtask

  task automatic test_timeout();
    i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 32'h4000_0010;
    @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({o_cyc, o_stb, i_err, i_ack, timeout_o} !== 5'b11000) begin
        bad++; $display("FAIL tmo_wait%0d: got cyc,stb,err,ack,tmo=%b want 11000", k, {o_cyc, o_stb, i_err, i_ack, timeout_o});
      end
      @(negedge clk_i);
    end
    total++;
    if ({o_cyc, o_stb, i_err, i_ack, timeout_o} !== 5'b00101) begin
      bad++; $display("FAIL tmo_resp: got cyc,stb,err,ack,tmo=%b want 00101", {o_cyc, o_stb, i_err, i_ack, timeout_o});
    end
    i_cyc = 0; i_stb = 0;
    @(negedge clk_i);
    total++;
    if ({i_err, timeout_o} !== 2'b00) begin
      bad++; $display("FAIL tmo_after: got err,tmo=%b want 00", {i_err, timeout_o});
    end
  endtask

  task automatic test_ack_at_timeout();
    i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 32'h4000_0014;
    repeat (4) @(negedge clk_i);
    o_ack = 1; o_dat_r = 32'hCAFE_F00D;
    @(negedge clk_i);
    o_ack = 0; o_dat_r = '0;
    total++;
    if ({i_ack, i_err, timeout_o} !== 3'b100 || i_dat_r !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL ack_at_tmo: got ack,err,tmo=%b dat=%h want 100 cafef00d", {i_ack, i_err, timeout_o}, i_dat_r);
    end
    i_cyc = 0; i_stb = 0;
    @(negedge clk_i);
  endtask

  task automatic test_ack_err_both();
    i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 32'h4000_0020;
    @(negedge clk_i);
    o_ack = 1; o_err = 1; o_dat_r = 32'h1234_5678;
    @(negedge clk_i);
    o_ack = 0; o_err = 0; o_dat_r = '0;
    total++;
    if ({i_err, i_ack, timeout_o} !== 3'b100) begin
      bad++; $display("FAIL both_term: got err,ack,tmo=%b want 100", {i_err, i_ack, timeout_o});
    end
    total++;
    if (i_dat_r !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL both_data: got %h want cafef00d", i_dat_r);
    end
    i_cyc = 0; i_stb = 0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_abort();
    i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 32'h4000_0040;
    @(negedge clk_i);
    total++;
    if (o_cyc !== 1'b1) begin
      bad++; $display("FAIL rst_pre: got cyc=%b want 1", o_cyc);
    end
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0; i_cyc = 0; i_stb = 0;
    total++;
    if ({o_cyc, o_stb, i_ack, i_err} !== 4'b0000 || i_dat_r !== 32'h0 || o_adr !== 16'h0) begin
      bad++; $display("FAIL rst_mid: got cyc,stb,ack,err=%b dat=%h adr=%h want 0000 0 0", {o_cyc, o_stb, i_ack, i_err}, i_dat_r, o_adr);
    end
    @(negedge clk_i);
    total++;
    if ({o_cyc, i_ack, i_err} !== 3'b000) begin
      bad++; $display("FAIL rst_after: got cyc,ack,err=%b want 000", {o_cyc, i_ack, i_err});
    end
    i_cyc = 1; i_stb = 1; i_adr = 32'h4000_0044;
    @(negedge clk_i);
    total++;
    if (o_cyc !== 1'b1 || o_adr !== 16'h0044) begin
      bad++; $display("FAIL abort_pre: got cyc=%b adr=%h want 1 0044", o_cyc, o_adr);
    end
    i_cyc = 0; i_stb = 0;
    @(negedge clk_i);
    total++;
    if ({o_cyc, o_stb, i_ack, i_err} !== 4'b0000) begin
      bad++; $display("FAIL abort_drop: got cyc,stb,ack,err=%b want 0000", {o_cyc, o_stb, i_ack, i_err});
    end
    o_ack = 1; o_dat_r = 32'h7777_7777;
    @(negedge clk_i);
    o_ack = 0; o_dat_r = '0;
    total++;
    if ({o_cyc, i_ack, i_err} !== 3'b000 || i_dat_r !== 32'h0) begin
      bad++; $display("FAIL abort_late: got cyc,ack,err=%b dat=%h want 000 0", {o_cyc, i_ack, i_err}, i_dat_r);
    end
    i_cyc = 1; i_stb = 1; i_adr = 32'h4000_0100;
    @(negedge clk_i);
    o_ack = 1; o_dat_r = 32'h0BAD_F00D;
    @(negedge clk_i);
    o_ack = 0; o_dat_r = '0;
    total++;
    if (i_ack !== 1'b1 || i_err !== 1'b0 || i_dat_r !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL abort_next: got ack=%b err=%b dat=%h want 1 0 0badf00d", i_ack, i_err, i_dat_r);
    end
    i_cyc = 0; i_stb = 0;
    @(negedge clk_i);
  endtask

  task automatic test_burst();
    i_cyc = 1; i_stb = 1; i_we = 1; i_cti = 3'b010; i_bte = 2'b00; i_sel = 4'h3;
    i_adr = 32'h4000_0200; i_dat_w = 32'hA5A5_0000;
    @(negedge clk_i);
    for (int b = 0; b < 4; b++) begin
      logic [15:0] exp_adr;
      logic [31:0] exp_dat;
      exp_adr = 16'h0200 + 16'(4 * b);
      exp_dat = 32'hA5A5_0000 + 32'(b);
      total++;
      if ({o_cyc, o_stb, o_we, o_cti, o_bte} !== 8'b111_000_00) begin
        bad++; $display("FAIL burst_ctl%0d: got cyc,stb,we,cti,bte=%b want 11100000", b, {o_cyc, o_stb, o_we, o_cti, o_bte});
      end
      total++;
      if (o_adr !== exp_adr || o_dat_w !== exp_dat || o_sel !== 4'h3) begin
        bad++; $display("FAIL burst_beat%0d: got adr=%h dat=%h sel=%h want %h %h 3", b, o_adr, o_dat_w, o_sel, exp_adr, exp_dat);
      end
      o_ack = 1;
      @(negedge clk_i);
      o_ack = 0;
      total++;
      if ({i_ack, i_err, o_cyc} !== 3'b100) begin
        bad++; $display("FAIL burst_ack%0d: got ack,err,cyc=%b want 100", b, {i_ack, i_err, o_cyc});
      end
      if (b < 3) begin
        i_adr   = 32'h4000_0200 + 32'(4 * (b + 1));
        i_dat_w = 32'hA5A5_0000 + 32'(b + 1);
        i_cti   = (b == 2) ? 3'b111 : 3'b010;
      end else begin
        i_cyc = 0; i_stb = 0; i_we = 0; i_cti = '0;
      end
      @(negedge clk_i);
      total++;
      if ({o_cyc, i_ack, i_err} !== 3'b000) begin
        bad++; $display("FAIL burst_gap%0d: got cyc,ack,err=%b want 000", b, {o_cyc, i_ack, i_err});
      end
      if (b < 3) @(negedge clk_i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_miss();
    test_timeout();
    test_ack_at_timeout();
    test_ack_err_both();
    test_reset_abort();
    test_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
